booth_r4_seq_mul: RTL and testbench

- Iterative radix-4 Booth multiplier for the TPU datapath.
- Accepts a multiplicand/multiplier pair over a valid/ready handshake, then scans the multiplier one radix-4 group per cycle.
- Each cycle it forms the Booth 3-bit encode, selects the partial product 0/±A/±2A, and accumulates it into a shifted running sum.
- Presents the full 2*DW-bit product over a valid/ready output handshake. Sits between the PE operand registers and the PE accumulate stage.

---
 rtl/booth_r4_seq_mul.sv | 160 ++++++++++++++++
 tb/tb_booth_r4_seq_mul.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/booth_r4_seq_mul.sv
// Iterative radix-4 Booth multiplier.
// Accepts an operand pair over a valid/ready handshake. It then retires one
// Booth group per cycle into a shifted running sum, and presents the
// 2*DW-bit product over a valid/ready output handshake.
module booth_r4_seq_mul #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_a,
  input  logic [DW-1:0]   in_b,
  input  logic            in_signed,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] out_product,
  output logic            busy
);

  localparam int GRP = DW / 2 + 1;     // Booth groups scanned
  localparam int AW  = DW + 2;         // extended operand width
  localparam int MW  = DW + 3;         // width that holds +/-2A
  localparam int ACW = 2 * DW + 4;     // accumulator width
  localparam int CW  = $clog2(GRP);    // group counter width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [CW-1:0]     cnt_r;
  logic [AW-1:0]     a_r;
  logic [AW:0]       b_r;          // {extended B, implicit b[-1]=0}
  logic [ACW-1:0]    acc_r;
  logic [2*DW-1:0]   product_r;

  logic [2:0]        dec_s;        // {negate, select 2A, select A}
  logic [MW-1:0]     mag_s;
  logic [MW-1:0]     pp_s;
  logic [ACW-1:0]    pp_ext_s;
  logic [ACW-1:0]    cin_ext_s;
  logic [CW:0]       shamt_s;
  logic [ACW-1:0]    acc_next_s;
  logic              last_grp_s;

  // Booth radix-4 recoding of one 3-bit window into {neg, two, one}.
  function automatic logic [2:0] booth_decode(input logic [2:0] enc);
    case (enc)
      3'b000, 3'b111: booth_decode = 3'b000;
      3'b001, 3'b010: booth_decode = 3'b001;
      3'b011:         booth_decode = 3'b010;
      3'b100:         booth_decode = 3'b110;
      3'b101, 3'b110: booth_decode = 3'b101;
      default:        booth_decode = 3'b000;
    endcase
  endfunction

  // Partial product selection and shifted accumulation for the current group.
  // A negative partial product is the one's complement plus a carry-in. The
  // carry-in is shifted into the same weight as the partial product.
  always_comb begin
    dec_s = booth_decode(b_r[2:0]);
    if (dec_s[0]) begin
      mag_s = {a_r[AW-1], a_r};
    end else if (dec_s[1]) begin
      mag_s = {a_r, 1'b0};
    end else begin
      mag_s = {MW{1'b0}};
    end
    if (dec_s[2]) begin
      pp_s = ~mag_s;
    end else begin
      pp_s = mag_s;
    end
    pp_ext_s   = {{(ACW-MW){pp_s[MW-1]}}, pp_s};
    cin_ext_s  = {{(ACW-1){1'b0}}, dec_s[2]};
    shamt_s    = {cnt_r, 1'b0};
    acc_next_s = acc_r + (pp_ext_s << shamt_s) + (cin_ext_s << shamt_s);
    last_grp_s = (cnt_r == CW'(GRP - 1));
  end

  // State register plus operand, counter, accumulator and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= {CW{1'b0}};
      a_r       <= {AW{1'b0}};
      b_r       <= {(AW+1){1'b0}};
      acc_r     <= {ACW{1'b0}};
      product_r <= {(2*DW){1'b0}};
    end else begin
      state_r <= state_next_s;
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r   <= {{2{in_signed & in_a[DW-1]}}, in_a};
            b_r   <= {{2{in_signed & in_b[DW-1]}}, in_b, 1'b0};
            acc_r <= {ACW{1'b0}};
            cnt_r <= {CW{1'b0}};
          end
        end
        RUN: begin
          acc_r <= acc_next_s;
          b_r   <= b_r >> 2;
          cnt_r <= cnt_r + CW'(1);
          if (last_grp_s) begin
            product_r <= acc_next_s[2*DW-1:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state logic and state-decoded handshake outputs.
  always_comb begin
    state_next_s = state_r;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_grp_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  assign out_product = product_r;

endmodule

// File: tb/tb_booth_r4_seq_mul.sv
// Self-checking bench for booth_r4_seq_mul. It uses directed corner cases
// plus randomized operands checked against an integer-arithmetic model.
module tb_booth_r4_seq_mul;

  localparam int DW  = 8;
  localparam int GRP = DW / 2 + 1;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_a;
  logic [DW-1:0]   in_b;
  logic            in_signed;
  logic            out_valid;
  logic            out_ready;
  logic [2*DW-1:0] out_product;
  logic            busy;

  int pass_cnt;
  int total_cnt;

  booth_r4_seq_mul #(.DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_signed   (in_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    total_cnt++;
    if (got == exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Exact integer product of the operands interpreted per mode, truncated.
  function automatic logic [2*DW-1:0] model(input logic [DW-1:0] a,
                                            input logic [DW-1:0] b,
                                            input logic s);
    longint pa;
    longint pb;
    longint p;
    pa = longint'(a);
    pb = longint'(b);
    if (s && a[DW-1]) pa = pa - (longint'(1) << DW);
    if (s && b[DW-1]) pb = pb - (longint'(1) << DW);
    p = pa * pb;
    return p[2*DW-1:0];
  endfunction

  // One full transaction: accept, wait for result, stall, then hand off.
  task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic s, input logic [2*DW-1:0] exp,
                        input int stall, input bit chk_lat, input bit rnd_rdy);
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      tick();
      cyc++;
    end
    check("in_ready_before", in_ready, 1);
    in_a      = a;
    in_b      = b;
    in_signed = s;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid  = 1'b0;
    in_a      = DW'($urandom);
    in_b      = DW'($urandom);
    in_signed = 1'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      if (rnd_rdy) out_ready = 1'($urandom);
      tick();
      cyc++;
    end
    check("out_valid_rise", out_valid, 1);
    if (chk_lat) check("latency", cyc, GRP);
    out_ready = 1'b0;
    for (int k = 0; k < stall; k++) begin
      in_valid = 1'b1;
      in_a     = DW'($urandom);
      in_b     = DW'($urandom);
      tick();
      check("stall_valid", out_valid, 1);
      check("stall_product", out_product, exp);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("product", out_product, exp);
    tick();
    out_ready = 1'b0;
    check("valid_drop", out_valid, 0);
    check("ready_after", in_ready, 1);
    check("busy_after", busy, 0);
  endtask

  initial begin
    int seen;
    logic [DW-1:0] ra;
    logic [DW-1:0] rb;
    logic          rs;
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_signed = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_product", out_product, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);

    run_op(8'h80, 8'h80, 1'b1, 16'h4000, 0, 1'b1, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b0, 16'hFE01, 0, 1'b1, 1'b0);
    run_op(8'hFF, 8'h02, 1'b1, 16'hFFFE, 0, 1'b0, 1'b0);
    run_op(8'hFF, 8'h02, 1'b0, 16'h01FE, 0, 1'b0, 1'b0);
    run_op(8'hFF, 8'h05, 1'b1, 16'hFFFB, 7, 1'b1, 1'b0);
    run_op(8'h00, 8'h00, 1'b1, 16'h0000, 0, 1'b1, 1'b0);
    run_op(8'h80, 8'h7F, 1'b1, 16'hC080, 1, 1'b1, 1'b0);

    // Abort an operation two cycles after acceptance.
    in_a      = 8'h55;
    in_b      = 8'h33;
    in_signed = 1'b0;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst  = 1'b0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (out_valid) seen++;
      tick();
    end
    check("abort_no_valid", seen, 0);
    check("abort_product", out_product, 0);
    check("abort_in_ready", in_ready, 1);
    run_op(8'd3, 8'd7, 1'b0, 16'h0015, 0, 1'b1, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      ra = DW'($urandom);
      rb = DW'($urandom);
      rs = 1'($urandom);
      run_op(ra, rb, rs, model(ra, rb, rs), int'($urandom_range(0, 2)), 1'b1, 1'b1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
